// File: rtl/dma_mem_access.sv
// dma_mem_access: memory-side DMA engine. Accepts one arbitrated byte
// request at a time, waits for a free memory bus slot, then runs a single
// SRAM read or write cycle of ACC_CYC clocks and reports completion.
//
// Handshake: dma_req acts as "valid" and the combinational dma_ack as
// "ready & valid". The request fields (dma_addr/dma_rnw/dma_wd) must stay
// stable while dma_req=1 and dma_ack=0. They are captured on the clock edge
// where dma_ack=1, and are ignored after that edge until the next ack.
// dma_end is a one-cycle completion pulse, and dma_rd is valid with it.
module dma_mem_access #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 8,
    parameter int ACC_CYC = 2    // strobe window length, 2..15 clocks
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rnw,
    input  logic [DATA_W-1:0] dma_wd,
    output logic              dma_ack,
    output logic              dma_end,
    output logic [DATA_W-1:0] dma_rd,
    input  logic              slot_en,
    output logic              dma_busy,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_do,
    output logic              mem_doe,
    input  logic [DATA_W-1:0] mem_di,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rnw_q, rnw_d;
    logic             oe_n_q, we_n_q, doe_q;
    logic             oe_n_d, we_n_d, doe_d;
    logic             accept;
    logic             rd_capture;

    // A new access can only begin from IDLE or FIN, and only when the
    // arbiter has handed us the bus this cycle. Reset masks ack at once.
    assign accept  = rst_n & dma_req & slot_en &
                     ((state_q == S_IDLE) || (state_q == S_FIN));
    assign dma_ack = accept;

    // Completion and bus ownership are decoded directly from the state.
    assign dma_end  = (state_q == S_FIN);
    assign dma_busy = (state_q != S_IDLE);

    // Read data is sampled in the last strobe cycle, after the longest settle time.
    assign rd_capture = (state_q == S_ACC) && (cnt_q == '0) && rnw_q;

    // Strobes come straight from flops, so the SRAM pins never glitch.
    assign mem_oe_n = oe_n_q;
    assign mem_we_n = we_n_q;
    assign mem_doe  = doe_q;

    // Next-state logic, plus the strobe levels the next state will need.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        doe_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACC;
                    cnt_d   = CNT_LOAD;
                    rnw_d   = dma_rnw;
                end
            end
            S_ACC: begin
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIN: begin
                if (accept) begin
                    state_d = S_ACC;
                    cnt_d   = CNT_LOAD;
                    rnw_d   = dma_rnw;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read: OE spans the whole window. Write: the data bus is driven for
        // the whole window, and WE is released one cycle early so the data
        // is still held when WE rises.
        if (state_d == S_ACC) begin
            if (rnw_d) begin
                oe_n_d = 1'b0;
            end else begin
                doe_d  = 1'b1;
                we_n_d = (cnt_d == '0);
            end
        end
    end

    // FSM, counter and latched direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rnw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
        end
    end

    // SRAM strobes. Async reset drops them immediately, even mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            doe_q  <= 1'b0;
        end else begin
            oe_n_q <= oe_n_d;
            we_n_q <= we_n_d;
            doe_q  <= doe_d;
        end
    end

    // Address and write data change only on an ack edge, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_a  <= '0;
            mem_do <= '0;
        end else if (accept) begin
            mem_a  <= dma_addr;
            mem_do <= dma_wd;
        end
    end

    // Read data register; written only by completing reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rd <= '0;
        end else if (rd_capture) begin
            dma_rd <= mem_di;
        end
    end

endmodule

// File: tb/tb_dma_mem_access.sv
// Testbench for dma_mem_access: one task per scenario, plus a monitor that
// pushes the expected dma_rd on every ack and checks it on every dma_end.
`timescale 1ns/1ps
module tb_dma_mem_access;

    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 8;
    localparam int ACC_CYC = 2;

    logic              clk;
    logic              rst_n;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_rnw;
    logic [DATA_W-1:0] dma_wd;
    logic              dma_ack;
    logic              dma_end;
    logic [DATA_W-1:0] dma_rd;
    logic              slot_en;
    logic              dma_busy;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_do;
    logic              mem_doe;
    logic [DATA_W-1:0] mem_di;
    logic              mem_oe_n;
    logic              mem_we_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_rd = '0;

    dma_mem_access #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ACC_CYC(ACC_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dma_req (dma_req),
        .dma_addr(dma_addr),
        .dma_rnw (dma_rnw),
        .dma_wd  (dma_wd),
        .dma_ack (dma_ack),
        .dma_end (dma_end),
        .dma_rd  (dma_rd),
        .slot_en (slot_en),
        .dma_busy(dma_busy),
        .mem_a   (mem_a),
        .mem_do  (mem_do),
        .mem_doe (mem_doe),
        .mem_di  (mem_di),
        .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n)
    );

    // Clock: 10 ns period, inputs change 1 ns after posedge, checks at negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: completions are checked before new acks are
    // recorded, so an end and an ack in the same cycle are handled in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dma_end) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_end: dma_end=1 with no outstanding access");
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if (dma_rd !== e) begin
                        n_fail++;
                        $display("FAIL sb_dma_rd: got %h expected %h", dma_rd, e);
                    end
                end
            end
            if (dma_ack) begin
                if (dma_rnw) model_rd = mem_di;
                exp_q.push_back(model_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic rnw, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd);
        dma_req  = 1'b1;
        dma_rnw  = rnw;
        dma_addr = a;
        dma_wd   = wd;
    endtask

    // Waits (bounded) for a dma_end at a negedge; a timeout counts as a failure.
    task automatic wait_end(input string name);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dma_end) begin
                seen = 1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: dma_end=0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        dma_req = 1'b1;
        slot_en = 1'b0;
        dma_rnw = 1'b1;
        dma_addr = 22'h000001;
        dma_wd  = 8'h00;
        mem_di  = 8'h3C;
        @(negedge clk);
        n_tests++;
        if ({dma_ack, dma_end, dma_busy, mem_doe, mem_oe_n, mem_we_n} !== 6'b000011 ||
            mem_a !== '0 || mem_do !== '0 || dma_rd !== '0) begin
            n_fail++;
            $display("FAIL reset_values: ack/end/busy/doe/oe_n/we_n=%b a=%h do=%h rd=%h expected 000011/0/0/0",
                     {dma_ack, dma_end, dma_busy, mem_doe, mem_oe_n, mem_we_n}, mem_a, mem_do, dma_rd);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({dma_ack, dma_busy, mem_doe, mem_oe_n, mem_we_n} !== 5'b00011) begin
                n_fail++;
                $display("FAIL idle_no_slot: ack/busy/doe/oe_n/we_n=%b expected 00011",
                         {dma_ack, dma_busy, mem_doe, mem_oe_n, mem_we_n});
            end
        end
        step();
        slot_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL slot_ack: dma_ack=%b expected 1", dma_ack);
        end
        step();
        dma_req = 1'b0;
        wait_end("reset_first_read");
    endtask

    task automatic test_read();
        step();
        mem_di = 8'hA5;
        drive_req(1'b1, 22'h012345, 8'h00);
        slot_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL read_ack: dma_ack=%b expected 1", dma_ack);
        end
        step();
        dma_req = 1'b0;
        for (int c = 1; c <= ACC_CYC; c++) begin
            @(negedge clk);
            n_tests++;
            if (mem_oe_n !== 1'b0 || mem_we_n !== 1'b1 || mem_doe !== 1'b0 ||
                mem_a !== 22'h012345 || dma_end !== 1'b0 || dma_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL read_acc T+%0d: oe_n=%b we_n=%b doe=%b a=%h end=%b busy=%b expected 0 1 0 012345 0 1",
                         c, mem_oe_n, mem_we_n, mem_doe, mem_a, dma_end, dma_busy);
            end
        end
        @(negedge clk);
        n_tests++;
        if (dma_end !== 1'b1 || dma_rd !== 8'hA5 || mem_oe_n !== 1'b1 || mem_a !== 22'h012345) begin
            n_fail++;
            $display("FAIL read_end: end=%b rd=%h oe_n=%b a=%h expected 1 a5 1 012345",
                     dma_end, dma_rd, mem_oe_n, mem_a);
        end
    endtask

    task automatic test_write();
        step();
        drive_req(1'b0, 22'h3FFFFF, 8'h5A);
        mem_di = 8'hEE;
        @(negedge clk);
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ack: dma_ack=%b expected 1", dma_ack);
        end
        step();
        dma_req = 1'b0;
        for (int c = 1; c <= ACC_CYC; c++) begin
            @(negedge clk);
            n_tests++;
            if (mem_doe !== 1'b1 || mem_we_n !== (c == ACC_CYC) || mem_oe_n !== 1'b1 ||
                mem_do !== 8'h5A || mem_a !== 22'h3FFFFF || dma_end !== 1'b0) begin
                n_fail++;
                $display("FAIL write_acc T+%0d: doe=%b we_n=%b oe_n=%b do=%h a=%h end=%b expected 1 %b 1 5a 3fffff 0",
                         c, mem_doe, mem_we_n, mem_oe_n, mem_do, mem_a, dma_end, (c == ACC_CYC));
            end
        end
        @(negedge clk);
        n_tests++;
        if (dma_end !== 1'b1 || dma_rd !== 8'hA5 || mem_doe !== 1'b0 || mem_we_n !== 1'b1) begin
            n_fail++;
            $display("FAIL write_end: end=%b rd=%h doe=%b we_n=%b expected 1 a5 0 1",
                     dma_end, dma_rd, mem_doe, mem_we_n);
        end
    endtask

    task automatic test_back_to_back();
        step();
        mem_di = 8'h96;
        drive_req(1'b1, 22'h000010, 8'h00);
        @(negedge clk);
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ack1: dma_ack=%b expected 1", dma_ack);
        end
        step();
        drive_req(1'b0, 22'h000011, 8'h77);
        for (int c = 1; c <= 2 * (ACC_CYC + 1); c++) begin
            logic exp_end, exp_ack;
            exp_end = (c == ACC_CYC + 1) || (c == 2 * (ACC_CYC + 1));
            exp_ack = (c == ACC_CYC + 1);
            @(negedge clk);
            n_tests++;
            if (dma_end !== exp_end || dma_ack !== exp_ack) begin
                n_fail++;
                $display("FAIL b2b T+%0d: end=%b ack=%b expected %b %b", c, dma_end, dma_ack, exp_end, exp_ack);
            end
            if (c == ACC_CYC + 1) begin
                step();
                dma_req = 1'b0;
            end
            if (c == ACC_CYC + 2) begin
                n_tests++;
                if (mem_a !== 22'h000011 || mem_do !== 8'h77 || mem_we_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_write: a=%h do=%h we_n=%b expected 000011 77 0", mem_a, mem_do, mem_we_n);
                end
            end
        end
    endtask

    task automatic test_slot_drop();
        step();
        mem_di = 8'h4B;
        drive_req(1'b1, 22'h0ABCDE, 8'h00);
        slot_en = 1'b1;
        @(negedge clk);
        step();
        slot_en = 1'b0;
        for (int c = 1; c <= ACC_CYC; c++) begin
            @(negedge clk);
            n_tests++;
            if (mem_oe_n !== 1'b0 || dma_end !== 1'b0) begin
                n_fail++;
                $display("FAIL slot_drop_acc T+%0d: oe_n=%b end=%b expected 0 0", c, mem_oe_n, dma_end);
            end
        end
        @(negedge clk);
        n_tests++;
        if (dma_end !== 1'b1 || dma_ack !== 1'b0 || dma_rd !== 8'h4B) begin
            n_fail++;
            $display("FAIL slot_drop_end: end=%b ack=%b rd=%h expected 1 0 4b", dma_end, dma_ack, dma_rd);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (dma_ack !== 1'b0 || dma_busy !== 1'b0 || mem_oe_n !== 1'b1) begin
                n_fail++;
                $display("FAIL slot_drop_wait: ack=%b busy=%b oe_n=%b expected 0 0 1", dma_ack, dma_busy, mem_oe_n);
            end
        end
        step();
        mem_di = 8'($urandom_range(0, 255));
        slot_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL slot_return_ack: dma_ack=%b expected 1", dma_ack);
        end
        step();
        dma_req = 1'b0;
        wait_end("slot_return");
    endtask

    task automatic test_reset_mid_write();
        step();
        drive_req(1'b0, 22'h155555, 8'hC3);
        slot_en = 1'b1;
        @(negedge clk);
        step();
        dma_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_we_n !== 1'b0 || mem_doe !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: we_n=%b doe=%b expected 0 1", mem_we_n, mem_doe);
        end
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_rd = '0;
        #1;
        n_tests++;
        if (mem_we_n !== 1'b1 || mem_doe !== 1'b0 || mem_oe_n !== 1'b1 || dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: we_n=%b doe=%b oe_n=%b busy=%b expected 1 0 1 0",
                     mem_we_n, mem_doe, mem_oe_n, dma_busy);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (dma_end !== 1'b0 || dma_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_end: end=%b busy=%b expected 0 0", dma_end, dma_busy);
            end
        end
        step();
        mem_di = 8'h69;
        drive_req(1'b1, 22'h000200, 8'h00);
        @(negedge clk);
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ack: dma_ack=%b expected 1", dma_ack);
        end
        step();
        dma_req = 1'b0;
        wait_end("post_reset");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_slot_drop();
        test_reset_mid_write();
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d outstanding accesses expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
